multicycle_control_fsm: RTL and testbench

- Main control unit of the multicycle RV32I core. Sits directly upstream of the ALU control block.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the 2-bit ALUOP and the 4-bit INSTRUCCION field (= {funct7[5], funct3}) that the ALU control decodes into ALUSELECT.
- Also drives datapath muxes, register/memory enables and PC/IR write strobes. Stalls on a memory-ready handshake.

---
 rtl/multicycle_control_fsm_if.sv | 47 ++++
 rtl/multicycle_control_fsm.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
// Optional build macro: ILLEGAL_TRAP_EN adds the ILLEGAL status line.
interface multicycle_control_fsm_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         OPCODE;
  logic [2:0]         FUNCT3;
  logic               FUNCT7_5;
  logic               ZERO;
  logic               MEM_READY;
  logic [1:0]         ALUOP;
  logic [3:0]         INSTRUCCION;
  logic               PCWRITE;
  logic               IRWRITE;
  logic               ADRSRC;
  logic               MEMREAD;
  logic               MEMWRITE;
  logic               REGWRITE;
  logic [1:0]         ALUSRCA;
  logic [1:0]         ALUSRCB;
  logic [1:0]         RESULTSRC;
  logic [1:0]         IMMSRC;
  logic [STATE_W-1:0] STATE;
`ifdef ILLEGAL_TRAP_EN
  logic               ILLEGAL;
`endif

  modport master (
    input  OPCODE, FUNCT3, FUNCT7_5, ZERO, MEM_READY,
    output ALUOP, INSTRUCCION, PCWRITE, IRWRITE, ADRSRC, MEMREAD, MEMWRITE,
           REGWRITE, ALUSRCA, ALUSRCB, RESULTSRC, IMMSRC,
`ifdef ILLEGAL_TRAP_EN
    output ILLEGAL,
`endif
    output STATE
  );

  modport slave (
    output OPCODE, FUNCT3, FUNCT7_5, ZERO, MEM_READY,
    input  ALUOP, INSTRUCCION, PCWRITE, IRWRITE, ADRSRC, MEMREAD, MEMWRITE,
           REGWRITE, ALUSRCA, ALUSRCB, RESULTSRC, IMMSRC,
`ifdef ILLEGAL_TRAP_EN
    input  ILLEGAL,
`endif
    input  STATE
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core; feeds ALUOP/INSTRUCCION to the ALU control.
// Optional build macro: ILLEGAL_TRAP_EN (unknown opcodes trap and raise ILLEGAL until reset).
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4 when memory is ready
// DECODE | branch target into ALUOUT, dispatch on opcode
// MEMADR | load/store address = RS1 + imm
// MEMRD  | load data read, waits on MEM_READY
// MEMWB  | load data to register file
// MEMWR  | store write, waits on MEM_READY
// EXECR  | R-type ALU operation
// EXECI  | I-type ALU operation
// ALUWB  | ALU result to register file
// BRANCH | BEQ compare, PC load on ZERO
// JAL    | PC <= target, then link OLDPC+4
// TRAP   | illegal opcode, idle with ILLEGAL set (ILLEGAL_TRAP_EN only)
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input logic                  CLK,
  input logic                  RST_N,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXECR  = STATE_W'(6),
    EXECI  = STATE_W'(7),
    ALUWB  = STATE_W'(8),
    BRANCH = STATE_W'(9),
`ifdef ILLEGAL_TRAP_EN
    JAL    = STATE_W'(10),
    TRAP   = STATE_W'(11)
`else
    JAL    = STATE_W'(10)
`endif
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t r_state;
  state_t w_next_state;
  logic   w_is_store;

  assign w_is_store = (bus.OPCODE == OP_STORE);
  assign bus.STATE  = r_state;

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state and Moore decode; PCWRITE/IRWRITE follow ZERO or MEM_READY where noted.
  always_comb begin
    w_next_state     = r_state;
    bus.ALUOP        = 2'b00;
    bus.INSTRUCCION  = 4'b0000;
    bus.PCWRITE      = 1'b0;
    bus.IRWRITE      = 1'b0;
    bus.ADRSRC       = 1'b0;
    bus.MEMREAD      = 1'b0;
    bus.MEMWRITE     = 1'b0;
    bus.REGWRITE     = 1'b0;
    bus.ALUSRCA      = 2'b00;
    bus.ALUSRCB      = 2'b00;
    bus.RESULTSRC    = 2'b00;
    bus.IMMSRC       = 2'b00;
`ifdef ILLEGAL_TRAP_EN
    bus.ILLEGAL      = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        bus.MEMREAD   = 1'b1;
        bus.ALUSRCB   = 2'b10;
        bus.ALUOP     = 2'b10;
        bus.RESULTSRC = 2'b10;
        bus.IRWRITE   = bus.MEM_READY;
        bus.PCWRITE   = bus.MEM_READY;
        if (bus.MEM_READY) w_next_state = DECODE;
      end
      DECODE: begin
        bus.ALUSRCA = 2'b01;
        bus.ALUSRCB = 2'b01;
        bus.IMMSRC  = 2'b10;
        bus.ALUOP   = 2'b10;
        case (bus.OPCODE)
          OP_R:              w_next_state = EXECR;
          OP_I:              w_next_state = EXECI;
          OP_LOAD, OP_STORE: w_next_state = MEMADR;
          OP_BEQ:            w_next_state = BRANCH;
          OP_JAL:            w_next_state = JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           w_next_state = TRAP;
`else
          default:           w_next_state = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        bus.ALUSRCA  = 2'b10;
        bus.ALUSRCB  = 2'b01;
        bus.ALUOP    = 2'b10;
        bus.IMMSRC   = w_is_store ? 2'b01 : 2'b00;
        w_next_state = w_is_store ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.ADRSRC  = 1'b1;
        bus.MEMREAD = 1'b1;
        if (bus.MEM_READY) w_next_state = MEMWB;
      end
      MEMWB: begin
        bus.RESULTSRC = 2'b01;
        bus.REGWRITE  = 1'b1;
        w_next_state  = FETCH;
      end
      MEMWR: begin
        bus.ADRSRC   = 1'b1;
        bus.MEMWRITE = 1'b1;
        if (bus.MEM_READY) w_next_state = FETCH;
      end
      EXECR: begin
        bus.ALUSRCA     = 2'b10;
        bus.INSTRUCCION = {bus.FUNCT7_5, bus.FUNCT3};
        w_next_state    = ALUWB;
      end
      EXECI: begin
        // Only shifts use funct7[5]; for ADDI etc. instr[30] is immediate data.
        bus.ALUSRCA     = 2'b10;
        bus.ALUSRCB     = 2'b01;
        bus.INSTRUCCION = {(bus.FUNCT3 == 3'b101) ? bus.FUNCT7_5 : 1'b0, bus.FUNCT3};
        w_next_state    = ALUWB;
      end
      ALUWB: begin
        bus.REGWRITE = 1'b1;
        w_next_state = FETCH;
      end
      BRANCH: begin
        bus.ALUSRCA  = 2'b10;
        bus.ALUOP    = 2'b01;
        bus.PCWRITE  = bus.ZERO;
        w_next_state = FETCH;
      end
      JAL: begin
        bus.ALUSRCA  = 2'b01;
        bus.ALUSRCB  = 2'b10;
        bus.ALUOP    = 2'b10;
        bus.PCWRITE  = 1'b1;
        w_next_state = ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        bus.ILLEGAL  = 1'b1;
        w_next_state = TRAP;
      end
`endif
      default: w_next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with an expected-output scoreboard.
module tb_multicycle_control_fsm;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  multicycle_control_fsm_if #(.STATE_W(4)) bus ();
  multicycle_control_fsm #(.STATE_W(4)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  typedef struct {
    string       tag;
    logic [24:0] v;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Expected outputs for a state, taken from the state table and the current inputs.
  function automatic logic [24:0] model(input logic [3:0] st);
    logic [1:0] aluop = 2'b00, srca = 2'b00, srcb = 2'b00, res = 2'b00, imm = 2'b00;
    logic [3:0] ins = 4'b0000;
    logic pcw = 0, irw = 0, adr = 0, mrd = 0, mwr = 0, rw = 0, ill = 0;
    case (st)
      4'd0: begin mrd = 1; srcb = 2'b10; aluop = 2'b10; res = 2'b10;
                  irw = bus.MEM_READY; pcw = bus.MEM_READY; end
      4'd1: begin srca = 2'b01; srcb = 2'b01; imm = 2'b10; aluop = 2'b10; end
      4'd2: begin srca = 2'b10; srcb = 2'b01; aluop = 2'b10;
                  imm = (bus.OPCODE == 7'b0100011) ? 2'b01 : 2'b00; end
      4'd3: begin adr = 1; mrd = 1; end
      4'd4: begin res = 2'b01; rw = 1; end
      4'd5: begin adr = 1; mwr = 1; end
      4'd6: begin srca = 2'b10; ins = {bus.FUNCT7_5, bus.FUNCT3}; end
      4'd7: begin srca = 2'b10; srcb = 2'b01;
                  ins = {(bus.FUNCT3 == 3'b101) ? bus.FUNCT7_5 : 1'b0, bus.FUNCT3}; end
      4'd8: begin rw = 1; end
      4'd9: begin srca = 2'b10; aluop = 2'b01; pcw = bus.ZERO; end
      4'd10: begin srca = 2'b01; srcb = 2'b10; aluop = 2'b10; pcw = 1; end
      4'd11: begin ill = 1; end
      default: ;
    endcase
    return {st, aluop, ins, pcw, irw, adr, mrd, mwr, rw, srca, srcb, res, imm, ill};
  endfunction

  function automatic logic [24:0] observed();
    logic ill;
`ifdef ILLEGAL_TRAP_EN
    ill = bus.ILLEGAL;
`else
    ill = 1'b0;
`endif
    return {bus.STATE, bus.ALUOP, bus.INSTRUCCION, bus.PCWRITE, bus.IRWRITE, bus.ADRSRC,
            bus.MEMREAD, bus.MEMWRITE, bus.REGWRITE, bus.ALUSRCA, bus.ALUSRCB,
            bus.RESULTSRC, bus.IMMSRC, ill};
  endfunction

  task automatic compare_head();
    exp_t e;
    logic [24:0] obs;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e   = sbq.pop_front();
    obs = observed();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
    end
    checks++;
    assert ((bus.MEMREAD & bus.MEMWRITE) === 1'b0) else begin
      errors++;
      $error("FAIL %s_rd_wr_exclusive observed=%b expected=0", e.tag, bus.MEMREAD & bus.MEMWRITE);
    end
  endtask

  // Queue the expectation for the current cycle, compare at the falling edge, advance one cycle.
  task automatic step(input string tag, input logic [3:0] st);
    exp_t e;
    e.tag = tag;
    e.v   = model(st);
    sbq.push_back(e);
    @(negedge CLK);
    compare_head();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.OPCODE    = 7'b0110011;
    bus.FUNCT3    = 3'b000;
    bus.FUNCT7_5  = 1'b1;
    bus.ZERO      = 1'b0;
    bus.MEM_READY = 1'b1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    step("reset", 4'd0);
    RST_N = 1'b1;

    // SUB then ADD
    step("sub_fetch", 4'd0); step("sub_decode", 4'd1); step("sub_execr", 4'd6); step("sub_aluwb", 4'd8);
    bus.FUNCT7_5 = 1'b0;
    step("add_fetch", 4'd0); step("add_decode", 4'd1); step("add_execr", 4'd6); step("add_aluwb", 4'd8);

    // ADDI with instr[30]=1, SRLI, SRAI
    bus.OPCODE = 7'b0010011; bus.FUNCT3 = 3'b000; bus.FUNCT7_5 = 1'b1;
    step("addi_fetch", 4'd0); step("addi_decode", 4'd1); step("addi_execi", 4'd7); step("addi_aluwb", 4'd8);
    bus.FUNCT3 = 3'b101; bus.FUNCT7_5 = 1'b0;
    step("srli_fetch", 4'd0); step("srli_decode", 4'd1); step("srli_execi", 4'd7); step("srli_aluwb", 4'd8);
    bus.FUNCT7_5 = 1'b1;
    step("srai_fetch", 4'd0); step("srai_decode", 4'd1); step("srai_execi", 4'd7); step("srai_aluwb", 4'd8);

    // LW with three wait cycles in MEMRD (8 cycles total)
    bus.OPCODE = 7'b0000011; bus.FUNCT3 = 3'b010; bus.FUNCT7_5 = 1'b0;
    step("lw_fetch", 4'd0); step("lw_decode", 4'd1); step("lw_memadr", 4'd2);
    bus.MEM_READY = 1'b0;
    step("lw_memrd_w0", 4'd3); step("lw_memrd_w1", 4'd3); step("lw_memrd_w2", 4'd3);
    bus.MEM_READY = 1'b1;
    step("lw_memrd_rdy", 4'd3); step("lw_memwb", 4'd4);

    // SW
    bus.OPCODE = 7'b0100011;
    step("sw_fetch", 4'd0); step("sw_decode", 4'd1); step("sw_memadr", 4'd2); step("sw_memwr", 4'd5);

    // BEQ taken and not taken
    bus.OPCODE = 7'b1100011; bus.FUNCT3 = 3'b000; bus.ZERO = 1'b1;
    step("beq_t_fetch", 4'd0); step("beq_t_decode", 4'd1); step("beq_t_branch", 4'd9);
    bus.ZERO = 1'b0;
    step("beq_n_fetch", 4'd0); step("beq_n_decode", 4'd1); step("beq_n_branch", 4'd9);

    // JAL
    bus.OPCODE = 7'b1101111;
    step("jal_fetch", 4'd0); step("jal_decode", 4'd1); step("jal_jal", 4'd10); step("jal_aluwb", 4'd8);

    // FETCH stall
    bus.OPCODE = 7'b0110011; bus.MEM_READY = 1'b0;
    step("fetch_stall0", 4'd0); step("fetch_stall1", 4'd0);
    bus.MEM_READY = 1'b1;
    step("fetch_go", 4'd0); step("fetch_go_decode", 4'd1); step("fetch_go_execr", 4'd6); step("fetch_go_aluwb", 4'd8);

    // Reset asserted while MEMWR is waiting
    bus.OPCODE = 7'b0100011;
    step("swr_fetch", 4'd0); step("swr_decode", 4'd1); step("swr_memadr", 4'd2);
    bus.MEM_READY = 1'b0;
    step("swr_memwr_w0", 4'd5);
    RST_N = 1'b0;
    step("swr_memwr_rst", 4'd5);
    step("swr_after_rst", 4'd0);
    RST_N = 1'b1; bus.MEM_READY = 1'b1;

    // Unknown opcode
    bus.OPCODE = 7'b1111111;
    step("ill_fetch", 4'd0); step("ill_decode", 4'd1);
`ifdef ILLEGAL_TRAP_EN
    step("ill_trap0", 4'd11); step("ill_trap1", 4'd11); step("ill_trap2", 4'd11);
    RST_N = 1'b0;
    step("ill_trap_rst", 4'd11);
    step("ill_after_rst", 4'd0);
    RST_N = 1'b1;
`else
    step("ill_nop_fetch", 4'd0); step("ill_nop_decode", 4'd1);
`endif
    step("final_fetch", 4'd0);

    if (sbq.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
